reg_file_swap_engine: RTL and testbench

//  Parametrised register file with an integrated memory-swap engine. Two async read ports, one sync

---
 rtl/reg_file_swap_engine_if.sv | 45 ++++
 rtl/reg_file_swap_engine.sv | 135 +++++++++++++
 tb/tb_reg_file_swap_engine.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_swap_engine_if.sv
// Register-file bus: two read ports, one write port, and the swap/copy command handshake.
// Defining REGF_OP_CHECK_EN adds op_err for rejected commands.
interface reg_file_swap_engine_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] A1;
    logic [ADDR_W-1:0] A2;
    logic [DATA_W-1:0] RD1;
    logic [DATA_W-1:0] RD2;
    logic [ADDR_W-1:0] A3;
    logic [DATA_W-1:0] WD3;
    logic              WE;
    logic              wr_stall;
    logic              op_valid;
    logic              op_ready;
    logic              op_code;
    logic [ADDR_W-1:0] op_a;
    logic [ADDR_W-1:0] op_b;
    logic              busy;
    logic              op_done;
`ifdef REGF_OP_CHECK_EN
    logic              op_err;
`endif

    modport master (
`ifdef REGF_OP_CHECK_EN
        input  op_err,
`endif
        output A1, A2, A3, WD3, WE,
        output op_valid, op_code, op_a, op_b,
        input  RD1, RD2, wr_stall,
        input  op_ready, busy, op_done
    );

    modport slave (
`ifdef REGF_OP_CHECK_EN
        output op_err,
`endif
        input  A1, A2, A3, WD3, WE,
        input  op_valid, op_code, op_a, op_b,
        output RD1, RD2, wr_stall,
        output op_ready, busy, op_done
    );
endinterface

// File: rtl/reg_file_swap_engine.sv
// Parametrised register file with a SWAP/COPY engine sharing the single write port.
// Defining REGF_OP_CHECK_EN rejects same-entry and zero-entry commands with op_err.
module reg_file_swap_engine #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    reg_file_swap_engine_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam bit ZR = (ZERO_REG != 0);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_MOVE, S_STORE, S_COPY, S_DONE
    } state_t;

    state_t state, state_nx;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] tmp;
    logic [ADDR_W-1:0] a_q, b_q;
    logic [DATA_W-1:0] rd_a, rd_b;
    logic              accept;
    logic              illegal;
    logic              wen;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;

    assign accept = bus.op_valid & bus.op_ready;

    assign bus.RD1 = (ZR && bus.A1 == '0) ? '0 : mem[bus.A1];
    assign bus.RD2 = (ZR && bus.A2 == '0) ? '0 : mem[bus.A2];
    assign rd_a    = (ZR && a_q == '0) ? '0 : mem[a_q];
    assign rd_b    = (ZR && b_q == '0) ? '0 : mem[b_q];

`ifdef REGF_OP_CHECK_EN
    logic err_q;
    assign illegal = (bus.op_a == bus.op_b) |
                     (ZR & ((bus.op_a == '0) | (bus.op_b == '0)));
`else
    assign illegal = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    if (illegal)          state_nx = S_DONE;
                    else if (bus.op_code) state_nx = S_COPY;
                    else                  state_nx = S_LOAD;
                end
            end
            S_LOAD:  state_nx = S_MOVE;
            S_MOVE:  state_nx = S_STORE;
            S_STORE: state_nx = S_DONE;
            S_COPY:  state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy     = (state != S_IDLE);
        bus.wr_stall = (state != S_IDLE);
        bus.op_ready = (state == S_IDLE) & rst;
        bus.op_done  = (state == S_DONE);
`ifdef REGF_OP_CHECK_EN
        bus.op_err   = (state == S_DONE) & err_q;
`endif
    end

    // External port owns the array only in IDLE; otherwise the engine does.
    always_comb begin
        wen   = 1'b0;
        waddr = bus.A3;
        wdata = bus.WD3;
        unique case (state)
            S_IDLE: wen = bus.WE;
            S_MOVE: begin
                wen   = 1'b1;
                waddr = a_q;
                wdata = rd_b;
            end
            S_STORE: begin
                wen   = 1'b1;
                waddr = b_q;
                wdata = tmp;
            end
            S_COPY: begin
                wen   = 1'b1;
                waddr = b_q;
                wdata = rd_a;
            end
            default: wen = 1'b0;
        endcase
        if (ZR && waddr == '0) wen = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wen) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmp <= '0;
            a_q <= '0;
            b_q <= '0;
        end else begin
            if (accept) begin
                a_q <= bus.op_a;
                b_q <= bus.op_b;
            end
            if (state == S_LOAD) tmp <= rd_a;
        end
    end

`ifdef REGF_OP_CHECK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        err_q <= 1'b0;
        else if (accept) err_q <= illegal;
    end
`endif
endmodule

// File: tb/tb_reg_file_swap_engine.sv
// Directed bench for reg_file_swap_engine: reset, SWAP, COPY, stalls, zero entry, back-to-back.
// Build with REGF_OP_CHECK_EN defined to exercise the command-check variant.
module tb_reg_file_swap_engine;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   lat;
    logic err_seen;
    int   pulses;
    int   accepts;
    int   overlap;

    always #5 clk = ~clk;

    reg_file_swap_engine_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    reg_file_swap_engine #(
        .DATA_W(32), .ADDR_W(5), .ZERO_REG(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd(input string tag, input logic [4:0] a,
                      input logic [31:0] exp);
        bus.A1 = a;
        bus.A2 = a;
        #1;
        chk({tag, ".rd1"}, bus.RD1, exp);
        chk({tag, ".rd2"}, bus.RD2, exp);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.WE  = 1'b1;
        bus.A3  = a;
        bus.WD3 = d;
        @(negedge clk);
        bus.WE  = 1'b0;
    endtask

    // Issues one command; optional write on the accept edge or during the first busy cycle.
    task automatic do_op(input logic code, input logic [4:0] a, input logic [4:0] b,
                         input bit same_we, input bit stall_we,
                         input logic [4:0] wa, input logic [31:0] wd,
                         output int l, output logic e);
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.op_code  = code;
        bus.op_a     = a;
        bus.op_b     = b;
        if (same_we) begin
            bus.WE  = 1'b1;
            bus.A3  = wa;
            bus.WD3 = wd;
        end
        l = 0;
        e = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 1) begin
                bus.op_valid = 1'b0;
                bus.WE  = stall_we;
                bus.A3  = wa;
                bus.WD3 = wd;
            end else begin
                bus.WE = 1'b0;
            end
            if (bus.op_done) begin
                l = i;
`ifdef REGF_OP_CHECK_EN
                e = bus.op_err;
`endif
                break;
            end
        end
        bus.WE = 1'b0;
    endtask

    initial begin
        bus.A1 = '0; bus.A2 = '0; bus.A3 = '0;
        bus.WD3 = '0; bus.WE = 1'b0;
        bus.op_valid = 1'b0; bus.op_code = 1'b0;
        bus.op_a = '0; bus.op_b = '0;

        // Reset, then abort a SWAP mid-flight with reset
        repeat (2) @(negedge clk);
        chk("rst.busy", {31'd0, bus.busy}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst.op_ready", {31'd0, bus.op_ready}, 32'd1);
        chk("rst.op_done", {31'd0, bus.op_done}, 32'd0);
        wr(5'd10, 32'h12345678);
        wr(5'd11, 32'h00000009);
        @(negedge clk);
        bus.op_valid = 1'b1; bus.op_code = 1'b0;
        bus.op_a = 5'd10; bus.op_b = 5'd11;
        @(negedge clk);
        bus.op_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rd("mid.r10", 5'd10, 32'h00000009);
        rd("mid.r11", 5'd11, 32'h00000009);
        chk("mid.wr_stall", {31'd0, bus.wr_stall}, 32'd1);
        chk("mid.op_ready", {31'd0, bus.op_ready}, 32'd0);
        rst = 1'b0;
        #1;
        rd("abort.r10", 5'd10, 32'h0);
        rd("abort.r11", 5'd11, 32'h0);
        chk("abort.busy", {31'd0, bus.busy}, 32'd0);
        chk("abort.op_done", {31'd0, bus.op_done}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.op_done) pulses++;
        end
        chk("abort.no_done", pulses, 0);
        chk("abort.op_ready", {31'd0, bus.op_ready}, 32'd1);
        wr(5'd5, 32'hA5A5A5A5);
        rd("r5", 5'd5, 32'hA5A5A5A5);

        // SWAP(3,7)
        wr(5'd3, 32'h11111111);
        wr(5'd7, 32'h22222222);
        do_op(1'b0, 5'd3, 5'd7, 1'b0, 1'b0, 5'd0, 32'd0, lat, err_seen);
        chk("swap.lat", lat, 4);
        chk("swap.err", {31'd0, err_seen}, 32'd0);
        rd("swap.r3", 5'd3, 32'h22222222);
        rd("swap.r7", 5'd7, 32'h11111111);

        // COPY(4,9) with a write attempt while stalled
        wr(5'd4, 32'hDEADBEEF);
        do_op(1'b1, 5'd4, 5'd9, 1'b0, 1'b1, 5'd9, 32'h1, lat, err_seen);
        chk("copy.lat", lat, 2);
        rd("copy.r9", 5'd9, 32'hDEADBEEF);
        rd("copy.r4", 5'd4, 32'hDEADBEEF);

        // Same-edge external write and SWAP accept
        do_op(1'b0, 5'd2, 5'd6, 1'b1, 1'b0, 5'd2, 32'hCAFE0000, lat, err_seen);
        chk("sameedge.lat", lat, 4);
        rd("sameedge.r6", 5'd6, 32'hCAFE0000);
        rd("sameedge.r2", 5'd2, 32'h0);

        // Entry 0 is hard-wired
        wr(5'd0, 32'hFFFFFFFF);
        rd("zero.r0", 5'd0, 32'h0);
        wr(5'd8, 32'h00000005);
        do_op(1'b0, 5'd0, 5'd8, 1'b0, 1'b0, 5'd0, 32'd0, lat, err_seen);
        rd("zswap.r0", 5'd0, 32'h0);
`ifdef REGF_OP_CHECK_EN
        chk("zswap.lat", lat, 1);
        chk("zswap.err", {31'd0, err_seen}, 32'd1);
        rd("zswap.r8", 5'd8, 32'h00000005);
`else
        chk("zswap.lat", lat, 4);
        rd("zswap.r8", 5'd8, 32'h0);
`endif

        // Same source and destination
        do_op(1'b1, 5'd5, 5'd5, 1'b0, 1'b0, 5'd0, 32'd0, lat, err_seen);
`ifdef REGF_OP_CHECK_EN
        chk("same.lat", lat, 1);
        chk("same.err", {31'd0, err_seen}, 32'd1);
`else
        chk("same.lat", lat, 2);
`endif
        rd("same.r5", 5'd5, 32'hA5A5A5A5);

        // op_valid held across two SWAP(1,2) commands
        wr(5'd1, 32'hAAAA0001);
        wr(5'd2, 32'hBBBB0002);
        pulses = 0;
        accepts = 0;
        overlap = 0;
        @(negedge clk);
        bus.op_valid = 1'b1; bus.op_code = 1'b0;
        bus.op_a = 5'd1; bus.op_b = 5'd2;
        for (int i = 0; i < 16; i++) begin
            #1;
            if (bus.op_valid && bus.op_ready) accepts++;
            if (bus.busy && bus.op_ready) overlap++;
            @(negedge clk);
            if (bus.op_done) pulses++;
            if (accepts == 2) bus.op_valid = 1'b0;
        end
        bus.op_valid = 1'b0;
        chk("b2b.accepts", accepts, 2);
        chk("b2b.pulses", pulses, 2);
        chk("b2b.overlap", overlap, 0);
        rd("b2b.r1", 5'd1, 32'hAAAA0001);
        rd("b2b.r2", 5'd2, 32'hBBBB0002);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
